sar_search: RTL and testbench

SAR_SEARCH -- requirements
Module: sar_search

---
 rtl/sar_search.sv | 137 +++++++++++++
 tb/tb_sar_search.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sar_search.sv
// Successive-approximation search that recovers a hidden target value
// by walking a trial value bit by bit against an external comparator.
module sar_search #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             eq,
    input  logic             lt,
    input  logic             gt,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       steps,
    output logic             err
);

    typedef enum logic {
        IDLE,
        TEST
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [2:0]       idx;
    logic [2:0]       idx_nx;
    logic [WIDTH-1:0] trial_nx;
    logic [WIDTH-1:0] result_nx;
    logic [WIDTH-1:0] bit_cur;
    logic [WIDTH-1:0] bit_low;
    logic [3:0]       steps_nx;
    logic             done_nx;
    logic             err_nx;
    logic [2:0]       flags;

    assign flags = {eq, lt, gt};
    assign busy  = (state == TEST);

    // State register, abandoned immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Datapath registers loaded from the next-value logic
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trial  <= '0;
            idx    <= '0;
            result <= '0;
            steps  <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            trial  <= trial_nx;
            idx    <= idx_nx;
            result <= result_nx;
            steps  <= steps_nx;
            done   <= done_nx;
            err    <= err_nx;
        end
    end

    // Next state and next datapath values; one bit resolved per TEST cycle
    always_comb begin
        state_nx  = state;
        trial_nx  = trial;
        idx_nx    = idx;
        result_nx = result;
        steps_nx  = steps;
        done_nx   = 1'b0;
        err_nx    = err;
        bit_cur   = {{(WIDTH-1){1'b0}}, 1'b1} << idx;
        bit_low   = bit_cur >> 1;
        unique case (state)
            IDLE: begin
                if (start) begin
                    trial_nx = {1'b1, {(WIDTH-1){1'b0}}};
                    idx_nx   = 3'(WIDTH-1);
                    steps_nx = '0;
                    err_nx   = 1'b0;
                    state_nx = TEST;
                end
            end
            TEST: begin
                steps_nx = steps + 4'd1;
                unique case (flags)
                    3'b100: begin
                        result_nx = trial;
                        done_nx   = 1'b1;
                        trial_nx  = '0;
                        state_nx  = IDLE;
                    end
                    3'b001: begin
                        if (idx == 3'd0) begin
                            result_nx = trial;
                            done_nx   = 1'b1;
                            trial_nx  = '0;
                            state_nx  = IDLE;
                        end else begin
                            trial_nx = trial | bit_low;
                            idx_nx   = idx - 3'd1;
                        end
                    end
                    3'b010: begin
                        if (idx == 3'd0) begin
                            result_nx = trial & ~bit_cur;
                            done_nx   = 1'b1;
                            trial_nx  = '0;
                            state_nx  = IDLE;
                        end else begin
                            trial_nx = (trial & ~bit_cur) | bit_low;
                            idx_nx   = idx - 3'd1;
                        end
                    end
                    default: begin
                        // Broken comparator: report and drop the search
                        err_nx    = 1'b1;
                        result_nx = '0;
                        trial_nx  = '0;
                        state_nx  = IDLE;
                    end
                endcase
            end
            default: begin
                state_nx = IDLE;
                trial_nx = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: a behavioural comparator answers each trial and an
// interval-halving model predicts the trial sequence, result and steps.
module tb_sar_search;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         eq;
    logic         lt;
    logic         gt;
    logic [W-1:0] trial;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [3:0]   steps;
    logic         err;

    logic [W-1:0] target = '0;
    logic         force_en = 1'b0;
    logic [2:0]   force_flags = 3'b000;

    int total = 0;
    int bad = 0;
    int exp_q[$];
    int obs_q[$];

    sar_search #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .eq(eq),
        .lt(lt),
        .gt(gt),
        .trial(trial),
        .busy(busy),
        .done(done),
        .result(result),
        .steps(steps),
        .err(err)
    );

    always #5 clk = ~clk;

    // Comparator against the hidden target, or forced flags
    assign eq = force_en ? force_flags[2] : (target == trial);
    assign lt = force_en ? force_flags[1] : (target < trial);
    assign gt = force_en ? force_flags[0] : (target > trial);

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Interval model: target lies in [lo, lo+size); probe the midpoint
    task automatic build_model(input int tgt);
        int lo;
        int size;
        int t;
        exp_q.delete();
        lo = 0;
        size = 1 << W;
        while (size > 1) begin
            t = lo + size / 2;
            exp_q.push_back(t);
            if (tgt == t) break;
            if (tgt > t) lo = t;
            size = size / 2;
        end
    endtask

    task automatic run_search(input int tgt, input bit hold);
        int k;
        build_model(tgt);
        obs_q.delete();
        target = W'(tgt);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        check("busy_go", 32'(busy), 1);
        check("done_go", 32'(done), 0);
        check("err_clr", 32'(err), 0);
        k = 0;
        while (!done && busy && k < 20) begin
            obs_q.push_back(int'(trial));
            check("trial_nz", 32'(trial != 0), 1);
            @(posedge clk);
            #1;
            k++;
        end
        check("done", 32'(done), 1);
        check("busy_end", 32'(busy), 0);
        check("result", 32'(result), 32'(tgt));
        check("steps", 32'(steps), 32'(exp_q.size()));
        check("seq_len", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check("seq", 32'(obs_q[i]), 32'(exp_q[i]));
        if (!hold) begin
            @(posedge clk);
            #1;
            check("done_pulse", 32'(done), 0);
            check("trial_idle", 32'(trial), 0);
        end
    endtask

    task automatic run_bad(input int tgt, input logic [2:0] code,
                           input int at_cycle);
        target = W'(tgt);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i < at_cycle; i++) begin
            @(posedge clk);
            #1;
        end
        force_en = 1'b1;
        force_flags = code;
        @(posedge clk);
        #1;
        force_en = 1'b0;
        check("bad_err", 32'(err), 1);
        check("bad_result", 32'(result), 0);
        check("bad_done", 32'(done), 0);
        check("bad_busy", 32'(busy), 0);
        check("bad_trial", 32'(trial), 0);
        check("bad_steps", 32'(steps), 32'(at_cycle));
        @(posedge clk);
        #1;
        check("bad_err_hold", 32'(err), 1);
        check("bad_done2", 32'(done), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_trial"}, 32'(trial), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_result"}, 32'(result), 0);
        check({tag, "_steps"}, 32'(steps), 0);
        check({tag, "_err"}, 32'(err), 0);
    endtask

    initial begin
        logic [2:0] codes [4];
        codes[0] = 3'b000;
        codes[1] = 3'b101;
        codes[2] = 3'b110;
        codes[3] = 3'b111;

        #2;
        rst = 1'b1;
        #1;
        check_zero("reset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_zero("post_reset");

        run_search(8, 1'b0);
        run_search(13, 1'b0);
        run_search(12, 1'b0);
        run_search(0, 1'b0);
        run_search(15, 1'b0);
        run_search(1, 1'b0);

        for (int n = 0; n < 20; n++)
            run_search(int'($urandom_range(0, (1 << W) - 1)), 1'b0);

        run_bad(5, 3'b011, 2);
        run_search(5, 1'b0);
        foreach (codes[c]) run_bad(9, codes[c], 1);
        run_search(9, 1'b0);

        target = 4'd13;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_zero("mid_rst");
        @(posedge clk);
        #1;
        check_zero("mid_rst_hold");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_nodone", 32'(done), 0);
        run_search(15, 1'b0);

        run_search(13, 1'b1);
        run_search(6, 1'b1);
        run_search(8, 1'b1);
        run_search(3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
